// File: rtl/xbus_latch_pkg.sv
// Shared types and constants for the xbus read-latch sequencer.
package xbus_latch_pkg;

  localparam int unsigned SETTLE_CYCLES_DEF = 2;
  localparam int unsigned TIMEOUT_DEF       = 255;
  localparam int unsigned TIMER_W           = 8;
  localparam int unsigned SETTLE_W          = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_ACK = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_HOLD     = 3'd3,
    ST_PRESENT  = 3'd4,
    ST_OUT      = 3'd5
  } xbus_state_e;

  typedef struct packed {
    logic bus_req;
    logic hold_n;
    logic oenb_n;
    logic busy;
  } xbus_ctl_t;

  // Moore decode of the latch/bus controls for a given state.
  function automatic xbus_ctl_t state_ctl(input xbus_state_e st);
    xbus_ctl_t c;
    c = '{bus_req: 1'b0, hold_n: 1'b0, oenb_n: 1'b1, busy: 1'b1};
    case (st)
      ST_IDLE:     c.busy = 1'b0;
      ST_WAIT_ACK: begin c.bus_req = 1'b1; c.hold_n = 1'b1; end
      ST_SETTLE:   begin c.bus_req = 1'b1; c.hold_n = 1'b1; end
      ST_HOLD:     c.hold_n = 1'b0;
      ST_PRESENT:  c.oenb_n = 1'b0;
      ST_OUT:      c.oenb_n = 1'b0;
      default:     c.busy = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/xbus_ack_sync.sv
// Two-flop synchronizer for the bus acknowledge, synchronous reset to 0.
module xbus_ack_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/xbus_latch_ctl.sv
// Read sequencer driving a 74S373-style latch bank: request, settle, freeze, capture, hand off.
// Optional XBUS_LATCH_ACK_SYNC_EN routes bus_ack through a 2-flop synchronizer.
module xbus_latch_ctl
  import xbus_latch_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned TIMEOUT       = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  output logic              bus_req,
  input  logic              bus_ack,
  output logic              lat_hold_n,
  output logic              lat_oenb_n,
  input  logic [DATA_W-1:0] lat_q,
  output logic [DATA_W-1:0] dat,
  output logic              dat_valid,
  input  logic              dat_ready,
  output logic              rd_err,
  output logic              busy
);

  logic ack_s;

`ifdef XBUS_LATCH_ACK_SYNC_EN
  xbus_ack_sync u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus_ack),
    .q_o   (ack_s)
  );
`else
  assign ack_s = bus_ack;
`endif

  xbus_state_e         state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                dat_valid_q;
  logic                rd_err_q, rd_err_d;
  xbus_ctl_t           ctl_q, ctl_d;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    settle_d = settle_q;
    dat_d    = dat_q;
    rd_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_req && !ack_s) begin
          state_d = ST_WAIT_ACK;
          timer_d = '0;
        end
      end
      ST_WAIT_ACK: begin
        if (timer_q != '1) timer_d = timer_q + 1'b1;
        // Ack is checked first so a coincident timeout loses.
        if (ack_s) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          state_d  = ST_IDLE;
          rd_err_d = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) state_d = ST_HOLD;
        else settle_d = settle_q + 1'b1;
      end
      ST_HOLD:    state_d = ST_PRESENT;
      ST_PRESENT: begin
        state_d = ST_OUT;
        dat_d   = lat_q;
      end
      ST_OUT:     if (dat_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they align with it.
    ctl_d = state_ctl(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      settle_q    <= '0;
      dat_q       <= '0;
      dat_valid_q <= 1'b0;
      rd_err_q    <= 1'b0;
      ctl_q       <= state_ctl(ST_IDLE);
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      settle_q    <= settle_d;
      dat_q       <= dat_d;
      dat_valid_q <= (state_d == ST_OUT);
      rd_err_q    <= rd_err_d;
      ctl_q       <= ctl_d;
    end
  end

  assign bus_req    = ctl_q.bus_req;
  assign lat_hold_n = ctl_q.hold_n;
  assign lat_oenb_n = ctl_q.oenb_n;
  assign busy       = ctl_q.busy;
  assign dat        = dat_q;
  assign dat_valid  = dat_valid_q;
  assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_xbus_latch_ctl.sv
// Scoreboard bench for xbus_latch_ctl; honours XBUS_LATCH_ACK_SYNC_EN for ack latency.
module tb_xbus_latch_ctl;

`ifdef XBUS_LATCH_ACK_SYNC_EN
  localparam int unsigned AD = 2;
`else
  localparam int unsigned AD = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, rd_req, bus_ack, dat_ready;
  logic [31:0] lat_q;
  logic        bus_req, lat_hold_n, lat_oenb_n, dat_valid, rd_err, busy;
  logic [31:0] dat;

  xbus_latch_ctl #(
    .DATA_W        (32),
    .SETTLE_CYCLES (2),
    .TIMEOUT       (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_req     (rd_req),
    .bus_req    (bus_req),
    .bus_ack    (bus_ack),
    .lat_hold_n (lat_hold_n),
    .lat_oenb_n (lat_oenb_n),
    .lat_q      (lat_q),
    .dat        (dat),
    .dat_valid  (dat_valid),
    .dat_ready  (dat_ready),
    .rd_err     (rd_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic [31:0] data;
    int unsigned edge_n;
  } exp_t;

  exp_t        dq[$];
  int unsigned eq[$];

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, "_bus_req"}, bus_req, 1'b0);
    chk1({tag, "_hold_n"}, lat_hold_n, 1'b0);
    chk1({tag, "_oenb_n"}, lat_oenb_n, 1'b1);
    chk32({tag, "_dat"}, dat, 32'h0);
    chk1({tag, "_dat_valid"}, dat_valid, 1'b0);
    chk1({tag, "_rd_err"}, rd_err, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: pops expectations whenever the DUT presents a word or an error.
  logic dv_prev = 1'b0;
  logic err_prev = 1'b0;
  always @(negedge clk) begin
    exp_t        e;
    int unsigned ee;
    if (dat_valid === 1'b1 && !dv_prev) begin
      if (dq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scb_unexpected_word at edge %0d: got dat=%h expected none", cyc, dat);
      end else begin
        e = dq.pop_front();
        chk32("scb_dat", dat, e.data);
        chk32("scb_valid_edge", cyc, e.edge_n);
      end
    end
    if (rd_err === 1'b1) begin
      if (err_prev) begin
        total++;
        bad++;
        $display("FAIL scb_rd_err_width at edge %0d: got 2+ cycles expected 1", cyc);
      end else if (eq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scb_unexpected_rd_err at edge %0d: got pulse expected none", cyc);
      end else begin
        ee = eq.pop_front();
        chk32("scb_rd_err_edge", cyc, ee);
      end
    end
    dv_prev  = (dat_valid === 1'b1);
    err_prev = (rd_err === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  int unsigned e0;

  initial begin
    reset = 1'b1; rd_req = 1'b0; bus_ack = 1'b0; lat_q = '0; dat_ready = 1'b1;
    tick(); tick();
    chk_reset("por");
    reset = 1'b0;
    tick();

    // Basic read with per-cycle control checks.
    lat_q = 32'hDEADBEEF; rd_req = 1'b1; e0 = cyc + 1;
    dq.push_back('{data: 32'hDEADBEEF, edge_n: e0 + 5 + AD});
    tick();
    for (int k = 0; k <= 7 + int'(AD); k++) begin
      chk1("basic_hold_n", lat_hold_n, k <= 2 + int'(AD));
      chk1("basic_bus_req", bus_req, k <= 2 + int'(AD));
      chk1("basic_oenb_n", lat_oenb_n, !(k >= 4 + int'(AD) && k <= 5 + int'(AD)));
      chk1("basic_dat_valid", dat_valid, k == 5 + int'(AD));
      chk1("basic_busy", busy, k <= 5 + int'(AD));
      if (k == 6 + int'(AD)) chk32("basic_dat_kept", dat, 32'hDEADBEEF);
      if (k == 0) begin rd_req = 1'b0; bus_ack = 1'b1; end
      if (k == 1) bus_ack = 1'b0;
      if (k == 5 + int'(AD)) lat_q = 32'h12345678;
      tick();
    end

    // Backpressure with an ignored rd_req during OUT.
    repeat (3) tick();
    dat_ready = 1'b0; lat_q = 32'hCAFEF00D; rd_req = 1'b1; e0 = cyc + 1;
    dq.push_back('{data: 32'hCAFEF00D, edge_n: e0 + 5 + AD});
    tick();
    rd_req = 1'b0; bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    repeat (4 + AD) tick();
    lat_q = 32'h0BADF00D;
    for (int i = 0; i < 10; i++) begin
      chk1("bp_dat_valid", dat_valid, 1'b1);
      chk32("bp_dat", dat, 32'hCAFEF00D);
      chk1("bp_oenb_n", lat_oenb_n, 1'b0);
      rd_req = (i == 3);
      tick();
    end
    rd_req = 1'b0; dat_ready = 1'b1;
    tick();
    chk1("bp_release_valid", dat_valid, 1'b0);
    chk1("bp_release_oenb_n", lat_oenb_n, 1'b1);
    chk1("bp_release_busy", busy, 1'b0);
    tick();
    chk1("bp_req_ignored_busy", busy, 1'b0);

    // Timeout: TIMEOUT=4, no ack.
    repeat (3) tick();
    rd_req = 1'b1; e0 = cyc + 1;
    eq.push_back(e0 + 4);
    tick();
    rd_req = 1'b0;
    repeat (4) tick();
    chk1("to_rd_err", rd_err, 1'b1);
    chk1("to_bus_req", bus_req, 1'b0);
    chk1("to_hold_n", lat_hold_n, 1'b0);
    chk1("to_busy", busy, 1'b0);
    tick();
    chk1("to_rd_err_clear", rd_err, 1'b0);
    chk1("to_dat_valid", dat_valid, 1'b0);

    // Ack coinciding with the final WAIT_ACK cycle: ack wins, no rd_err.
    lat_q = 32'hA5A55A5A; rd_req = 1'b1; e0 = cyc + 1;
    dq.push_back('{data: 32'hA5A55A5A, edge_n: e0 + 8});
    tick();
    rd_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus_ack = (k == 3 - int'(AD));
      tick();
    end
    bus_ack = 1'b0;
    chk1("coinc_dat_valid", dat_valid, 1'b1);
    tick();
    chk1("coinc_idle", busy, 1'b0);

    // Reset while in SETTLE.
    repeat (3) tick();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0; bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    repeat (AD) tick();
    chk1("rst_settle_reached", bus_req & lat_hold_n, 1'b1);
    reset = 1'b1;
    tick();
    chk_reset("rst_settle");
    reset = 1'b0;
    repeat (3) tick();

    // Reset while in OUT.
    dat_ready = 1'b0; lat_q = 32'h0F0F1234; rd_req = 1'b1; e0 = cyc + 1;
    dq.push_back('{data: 32'h0F0F1234, edge_n: e0 + 5 + AD});
    tick();
    rd_req = 1'b0; bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    repeat (4 + AD) tick();
    chk1("rst_out_reached", dat_valid, 1'b1);
    reset = 1'b1;
    tick();
    chk_reset("rst_out");
    reset = 1'b0; dat_ready = 1'b1;
    repeat (4) tick();

    chk32("scb_drained", dq.size() + eq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xbus_latch_ctl.md
Name: xbus_latch_ctl

Overview:
Sequencer that sits directly upstream of a bank of octal transparent latches (part_74S373-style, HOLD_N/OENB_N controls) on the bus read-data path.
- Issues a bus read request and opens the latches while bus data settles.
- Freezes the latches, enables their outputs, and captures the latched word into a register.
- Hands the word to the consumer over a valid/ready handshake, and flags a timeout when the bus never acknowledges.

Parameters:
DATA_W, 32, width of latch bank output / captured word (multiple of 8)
SETTLE_CYCLES, 2, cycles the latches stay transparent after ack (legal range 1..15)
TIMEOUT, 255, WAIT_ACK cycles before abort (legal range 2..255, 8-bit timer)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rd_req  in  1  consumer requests one bus read; sampled only in IDLE
bus_req  out  1  read request to bus
bus_ack  in  1  bus acknowledge; data valid on bus while high
lat_hold_n  out  1  to latch HOLD_N; 1 = transparent, 0 = hold
lat_oenb_n  out  1  to latch OENB_N; 0 = outputs driven
lat_q  in  DATA_W  latch bank outputs
dat  out  DATA_W  captured read word
dat_valid  out  1  dat holds a valid word
dat_ready  in  1  consumer accepts dat
rd_err  out  1  one-cycle pulse on timeout
busy  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, WAIT_ACK, SETTLE, HOLD, PRESENT, OUT. All outputs are registered.
- Reset (synchronous, one cycle, any state): state=IDLE, bus_req=0, lat_hold_n=0, lat_oenb_n=1, dat=0, dat_valid=0, rd_err=0, busy=0, timer=0, settle count=0. Reset mid-transfer drops bus_req on the next edge and discards any word.
- IDLE: lat_hold_n=0, lat_oenb_n=1. If rd_req=1 and bus_ack=0 -> WAIT_ACK and clear timer. If rd_req=1 while bus_ack is still high from the prior cycle, the request is held off until bus_ack=0.
- WAIT_ACK: bus_req=1, lat_hold_n=1, timer increments each cycle.
  - bus_ack=1 -> SETTLE with settle count=0.
  - If timer==TIMEOUT-1 and bus_ack=0 -> IDLE, rd_err=1 for exactly one cycle, bus_req=0, lat_hold_n=0.
  - If ack and timeout coincide, ack wins.
- SETTLE: bus_req=1, lat_hold_n=1. Stays SETTLE_CYCLES cycles, then -> HOLD.
- HOLD: lat_hold_n=0 (latches frozen), bus_req=0. One cycle, -> PRESENT.
- PRESENT: lat_oenb_n=0. One cycle. At its closing edge, dat<=lat_q, dat_valid<=1, -> OUT.
- OUT: lat_oenb_n=0, dat stable, dat_valid=1.
  - dat_valid & dat_ready at an edge -> IDLE, dat_valid=0, lat_oenb_n=1. dat keeps its last value.
  - rd_req is ignored while busy.
- Latency: if rd_req is sampled at edge 0 and bus_ack=1 at edge a (a>=1), dat_valid rises after edge a+SETTLE_CYCLES+2. With the default SETTLE_CYCLES and a=1, that is after edge 5.
- Back-to-back: minimum one IDLE cycle between transfers.
- bus_ack dropping during SETTLE does not abort the transfer; the latched data is taken as is.
- Timer saturates; it never wraps.

Optional Feature:
XBUS_LATCH_ACK_SYNC_EN
- Defined: bus_ack passes through a 2-flop synchronizer before use. Ack-dependent transitions (including the IDLE ack-low check) are delayed 2 cycles, so all ack-relative latencies grow by 2. The timeout still counts raw WAIT_ACK cycles.
- Undefined: bus_ack is used directly and must be synchronous to clk.

Decomposition:
- Shared package xbus_latch_pkg holds:
  - state encoding: 3-bit localparams ST_IDLE=0, ST_WAIT_ACK=1, ST_SETTLE=2, ST_HOLD=3, ST_PRESENT=4, ST_OUT=5
  - default SETTLE_CYCLES and TIMEOUT constants
  - timer width constant (8)
- One sub-module: xbus_ack_sync (2-flop synchronizer, 1-bit, sync reset to 0), instantiated only under the macro.

Test Plan:
- Basic read: reset, rd_req=1 for one cycle, bus_ack=1 from edge 1, lat_q=32'hDEADBEEF, dat_ready=1 -> dat_valid high one cycle after edge 5; dat=32'hDEADBEEF; lat_hold_n=1 edges 1..3; lat_hold_n=0 at HOLD; lat_oenb_n=0 in PRESENT/OUT; back to IDLE.
- Backpressure: dat_ready=0 for 10 cycles -> dat_valid and dat stable; lat_oenb_n=0 throughout; a rd_req pulse during OUT is ignored. dat_ready=1 -> IDLE, lat_oenb_n=1.
- Timeout: TIMEOUT=4, bus_ack never asserted -> rd_err single pulse after 4 WAIT_ACK cycles; bus_req=0; dat_valid stays 0; next rd_req is accepted.
- Ack/timeout coincidence: bus_ack rises in the final WAIT_ACK cycle -> no rd_err; normal completion.
- Reset mid-operation: assert reset in SETTLE and in OUT -> next edge shows every output at its reset value.
- With XBUS_LATCH_ACK_SYNC_EN: basic-read stimulus -> dat_valid rises 2 cycles later than without the macro.
